// File: rtl/down_counter_32_pkg.sv
// Shared types and constants for the 32-bit loadable down-counter/timer.
package down_counter_32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] DEC_OPERAND = 32'hFFFF_FFFF;

endpackage

// File: rtl/adder_32.sv
// 32-bit ripple-carry adder: {Cout, S} = A + B + Cin.
module adder_32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout
);

  logic w_carry;

  always_comb begin
    S       = '0;
    w_carry = Cin;
    for (int unsigned i = 0; i < 32; i++) begin
      S[i]    = A[i] ^ B[i] ^ w_carry;
      w_carry = (A[i] & B[i]) | (w_carry & (A[i] ^ B[i]));
    end
    Cout = w_carry;
  end

endmodule

// File: rtl/down_counter_32.sv
// 32-bit loadable down-counter/timer with pause, one-shot done pulse and optional auto-reload.
module down_counter_32
  import down_counter_32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        start,
  input  logic        pause,
  input  logic        auto_reload,
  output logic [31:0] q,
  output logic        busy,
  output logic        done
);

  state_t      r_state;
  logic [31:0] r_q;
  logic [31:0] r_reload;
  logic        r_busy;
  logic        r_done;
  logic [31:0] w_dec;
  logic        w_q_nonzero;

  // q + all-ones carries out exactly when q != 0, so Cout doubles as the nonzero test.
  adder_32 u_dec (
    .A    (r_q),
    .B    (DEC_OPERAND),
    .Cin  (1'b0),
    .S    (w_dec),
    .Cout (w_q_nonzero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (load) begin
      r_state  <= IDLE;
      r_q      <= load_value;
      r_reload <= load_value;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (w_q_nonzero) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        // HOLD releasing counts on the same edge, so each pause cycle costs exactly one cycle.
        RUN, HOLD: begin
          if (pause) begin
            r_state <= HOLD;
          end else if (r_q == 32'd1) begin
            r_done <= 1'b1;
            if (auto_reload && (r_reload != '0)) begin
              r_state <= RUN;
              r_q     <= r_reload;
            end else begin
              r_state <= IDLE;
              r_q     <= '0;
              r_busy  <= 1'b0;
            end
          end else begin
            r_state <= RUN;
            r_q     <= w_dec;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign q    = r_q;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_down_counter_32.sv
// Directed self-checking bench for down_counter_32.
module tb_down_counter_32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [31:0] load_value = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        auto_reload = 1'b0;
  logic [31:0] q;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  down_counter_32 dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_value  (load_value),
    .start       (start),
    .pause       (pause),
    .auto_reload (auto_reload),
    .q           (q),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] eq, input logic eb, input logic ed);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
  endtask

  task automatic do_load(input logic [31:0] v);
    load = 1'b1;
    load_value = v;
    tick();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] ar_q [7];
    logic        ar_d [7];
    ar_q = '{32'd2, 32'd1, 32'd3, 32'd2, 32'd1, 32'd3, 32'd2};
    ar_d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset
    tick();
    chk_all("reset", 32'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Load 5, start, count 5..0
    do_load(32'd5);
    chk_all("load5", 32'd5, 1'b0, 1'b0);
    do_start();
    chk_all("start5", 32'd5, 1'b1, 1'b0);
    for (int k = 4; k >= 1; k--) begin
      tick();
      chk_all("run5", k, 1'b1, 1'b0);
    end
    tick();
    chk_all("zero5", 32'd0, 1'b0, 1'b1);
    tick();
    chk_all("after5", 32'd0, 1'b0, 1'b0);

    // Auto-reload with 3
    auto_reload = 1'b1;
    do_load(32'd3);
    do_start();
    chk_all("ar_start", 32'd3, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk_all("ar_run", ar_q[k], 1'b1, ar_d[k]);
    end
    auto_reload = 1'b0;
    tick();
    chk_all("ar_off1", 32'd1, 1'b1, 1'b0);
    tick();
    chk_all("ar_off0", 32'd0, 1'b0, 1'b1);

    // Pause 4 cycles at q=7, done 14 cycles after start
    do_load(32'd10);
    do_start();
    chk_all("p_start", 32'd10, 1'b1, 1'b0);
    for (int k = 9; k >= 7; k--) begin
      tick();
      chk_all("p_pre", k, 1'b1, 1'b0);
    end
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all("p_hold", 32'd7, 1'b1, 1'b0);
    end
    pause = 1'b0;
    for (int k = 6; k >= 1; k--) begin
      tick();
      chk_all("p_post", k, 1'b1, 1'b0);
    end
    tick();
    chk_all("p_done", 32'd0, 1'b0, 1'b1);

    // Zero-length start
    do_load(32'd0);
    do_start();
    chk_all("z_start", 32'd0, 1'b0, 1'b1);
    tick();
    chk_all("z_after", 32'd0, 1'b0, 1'b0);

    // Load abort mid-run
    do_load(32'd8);
    do_start();
    for (int k = 7; k >= 4; k--) begin
      tick();
      chk_all("ab_run", k, 1'b1, 1'b0);
    end
    do_load(32'd20);
    chk_all("ab_load", 32'd20, 1'b0, 1'b0);
    tick();
    chk_all("ab_idle", 32'd20, 1'b0, 1'b0);
    do_start();
    chk_all("ab_start", 32'd20, 1'b1, 1'b0);
    for (int k = 19; k >= 1; k--) begin
      tick();
      chk_all("ab_run20", k, 1'b1, 1'b0);
    end
    tick();
    chk_all("ab_done", 32'd0, 1'b0, 1'b1);

    // Reset mid-run on max value
    do_load(32'hFFFF_FFFF);
    do_start();
    chk_all("rs_start", 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    chk_all("rs_pre", 32'hFFFF_FFFC, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all("rs_reset", 32'd0, 1'b0, 1'b0);
    do_start();
    chk_all("rs_zstart", 32'd0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
